// File: rtl/spi_slave_param.sv
// spi_slave_param: parameterised SPI slave.
// All SPI inputs are synchronised into clk and every decision is made from
// the synchronised copies and their delayed versions.
// Received words go out on rx_data with a valid/ack handshake. Transmit words
// come in through a one-deep holding register.
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   sclk, cs, mosi        SPI bus from the master (asynchronous to clk)
//   miso                  serial data out, 0 while deselected
//   rx_data, rx_valid     last complete word, and whether it is still unacknowledged
//   rx_ack                consumer acknowledge
//   rx_overrun            1-cycle pulse when an unacknowledged word is overwritten
//   tx_data, tx_load      word to transmit, and its write strobe
//   tx_ready              holding register empty
//   frame_err             1-cycle pulse when cs rises in the middle of a word
//   busy                  synchronised cs is low
//
// state  | meaning
// IDLE   | deselected; sclk edges are ignored, miso held at 0
// ACTIVE | selected; sample/shift edges move data through the shifters
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              frame_err,
    output logic              busy
);

    localparam int               CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(DATA_W - 1);
    localparam logic             SCLK_IDLE   = (CPOL != 0);
    localparam logic             SAMPLE_RISE = (CPOL == CPHA);
    localparam logic             MSB_ORDER   = (MSB_FIRST != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic sclk_rise, sclk_fall, sample_edge, shift_edge, cs_fall, cs_rise;
    logic active;

    logic [CNT_W-1:0]  bit_cnt, cnt_after;
    logic [DATA_W-1:0] rx_shift, rx_word;
    logic [DATA_W-1:0] hold_reg, tx_shift, tx_src;
    logic              hold_full, miso_q;
    logic              do_sample, last_bit, word_done, word_start, do_shift, frame_abort;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_ORDER ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return MSB_ORDER ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    // Synchronisers reset to the bus idle levels so release of reset with
    // the bus idle produces no spurious edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= SCLK_IDLE;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign cs_fall     = ~cs_s & cs_d;
    assign cs_rise     = cs_s & ~cs_d;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        active = 1'b0;
        miso   = 1'b0;
        busy   = ~cs_s;
        case (state)
            ACTIVE: begin
                active = 1'b1;
                miso   = miso_q & ~cs_s;
            end
            default: ;
        endcase
    end

    assign do_sample = active & sample_edge;
    assign last_bit  = (bit_cnt == LAST_CNT);
    assign word_done = do_sample & last_bit;
    assign rx_word   = MSB_ORDER ? {rx_shift[DATA_W-2:0], mosi_s}
                                 : {mosi_s, rx_shift[DATA_W-1:1]};
    assign cnt_after = do_sample ? (last_bit ? '0 : bit_cnt + CNT_W'(1)) : bit_cnt;

    // A final sample landing together with the cs rise completes the word,
    // so the abort decision looks at the count after this cycle's sample.
    assign frame_abort = active & cs_rise & (cnt_after != '0);

    // Word start: cs fall, or counter wrap while the frame is still selected.
    assign word_start = (~active & cs_fall) | (word_done & ~cs_s);

    // With CPHA=0 the first bit is presented at word start, so the shift
    // edge that follows the last sample of a word (count already wrapped)
    // must not advance the new word.
    assign do_shift = active & shift_edge & ((CPHA != 0) | (bit_cnt != '0));
    assign tx_src   = hold_full ? hold_reg : '0;
    assign tx_ready = ~hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            bit_cnt    <= active ? cnt_after : '0;
            rx_overrun <= 1'b0;
            frame_err  <= frame_abort;
            if (do_sample) rx_shift <= rx_word;
            if (word_done) begin
                rx_data    <= rx_word;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            tx_shift  <= '0;
            miso_q    <= 1'b0;
        end else begin
            if (word_start) begin
                hold_full <= 1'b0;
                if (CPHA == 0) begin
                    miso_q   <= first_bit(tx_src);
                    tx_shift <= advance(tx_src);
                end else begin
                    tx_shift <= tx_src;
                end
            end else if (do_shift) begin
                miso_q   <= first_bit(tx_shift);
                tx_shift <= advance(tx_shift);
            end
            // A load accepted in a word-start cycle refills the register
            // after the (empty) transfer, so it goes out in the next word.
            if (tx_load && !hold_full) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: the bench acts as SPI master for two instances,
// mode 0 / 8-bit / MSB first, and mode 3 / 16-bit / LSB first.
module tb_spi_slave_param;

    localparam int H0 = 62;
    localparam int H1 = 100;

    logic clk = 1'b0;
    logic rst_n;

    logic        sclk0, cs0, mosi0, miso0, rx_valid0, rx_ack0, rx_overrun0;
    logic        tx_load0, tx_ready0, frame_err0, busy0;
    logic [7:0]  rx_data0, tx_data0;

    logic        sclk1, cs1, mosi1, miso1, rx_valid1, rx_ack1, rx_overrun1;
    logic        tx_load1, tx_ready1, frame_err1, busy1;
    logic [15:0] rx_data1, tx_data1;

    int checks = 0;
    int failures = 0;
    int ovr0 = 0, ferr0 = 0, ovr1 = 0, ferr1 = 0;
    logic [15:0] got1[$];

    always #10 clk = ~clk;

    spi_slave_param dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs(cs0), .mosi(mosi0), .miso(miso0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ack(rx_ack0), .rx_overrun(rx_overrun0),
        .tx_data(tx_data0), .tx_load(tx_load0), .tx_ready(tx_ready0),
        .frame_err(frame_err0), .busy(busy0)
    );

    spi_slave_param #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ack(rx_ack1), .rx_overrun(rx_overrun1),
        .tx_data(tx_data1), .tx_load(tx_load1), .tx_ready(tx_ready1),
        .frame_err(frame_err1), .busy(busy1)
    );

    // Pulse counters: each count is the number of cycles the pulse was high.
    always @(posedge clk) begin
        if (rx_overrun0) ovr0  <= ovr0 + 1;
        if (frame_err0)  ferr0 <= ferr0 + 1;
        if (rx_overrun1) ovr1  <= ovr1 + 1;
        if (frame_err1)  ferr1 <= ferr1 + 1;
    end

    // Consumer for dut1: collect every word and acknowledge it at once.
    initial begin
        rx_ack1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_ack1) rx_ack1 = 1'b0;
            else if (rx_valid1) begin
                got1.push_back(rx_data1);
                rx_ack1 = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack0();
        @(negedge clk) rx_ack0 = 1'b1;
        @(negedge clk) rx_ack0 = 1'b0;
    endtask

    task automatic load0(input logic [7:0] v);
        @(negedge clk);
        tx_data0 = v;
        tx_load0 = 1'b1;
        @(negedge clk) tx_load0 = 1'b0;
    endtask

    // Mode 0 master: mosi set while sclk low, miso captured just before rise.
    task automatic spi0_bits(input logic [7:0] w, input int nbits, output logic [7:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi0 = w[7-i];
            #H0;
            rd[7-i] = miso0;
            sclk0 = 1'b1;
            #H0;
            sclk0 = 1'b0;
        end
    endtask

    task automatic spi0_frame(input logic [7:0] w, output logic [7:0] rd);
        cs0 = 1'b0;
        #(2*H0);
        spi0_bits(w, 8, rd);
        #H0;
        cs0 = 1'b1;
        wait_cycles(8);
    endtask

    // Mode 3, LSB first master: leading (falling) edge drives, rising edge samples.
    task automatic spi1_bits(input logic [15:0] w, input int nbits, output logic [15:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            sclk1 = 1'b0;
            mosi1 = w[i];
            #H1;
            rd[i] = miso1;
            sclk1 = 1'b1;
            #H1;
        end
    endtask

    initial begin
        logic [7:0]  rd, ra, rb, w, wa, wb, t;
        logic [7:0]  exp_rx0;
        logic [15:0] rd1a, rd1b, rd1c, w1, t1;
        int f0, o0, f1, o1, nq;
        bit do_load;

        rst_n = 1'b0;
        sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; rx_ack0 = 1'b0; tx_data0 = '0; tx_load0 = 1'b0;
        sclk1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0; tx_data1 = '0; tx_load1 = 1'b0;
        exp_rx0 = '0;
        wait_cycles(3);

        chk("rst_miso",     miso0, 1'b0);
        chk("rst_rx_data",  rx_data0, 8'h00);
        chk("rst_rx_valid", rx_valid0, 1'b0);
        chk("rst_overrun",  rx_overrun0, 1'b0);
        chk("rst_tx_ready", tx_ready0, 1'b1);
        chk("rst_frame_err", frame_err0, 1'b0);
        chk("rst_busy",     busy0, 1'b0);

        rst_n = 1'b1;
        wait_cycles(4);

        // One frame of 0xAA, nothing loaded for transmit.
        f0 = ferr0;
        spi0_frame(8'hAA, rd);
        exp_rx0 = 8'hAA;
        chk("aa_rx_data", rx_data0, exp_rx0);
        chk("aa_rx_valid", rx_valid0, 1'b1);
        chk("aa_frame_err", ferr0 - f0, 0);
        chk("aa_miso_empty", rd, 8'h00);
        ack0();
        chk("ack_clears", rx_valid0, 1'b0);

        // Two frames with no acknowledge in between.
        o0 = ovr0;
        spi0_frame(8'h33, rd);
        spi0_frame(8'hFF, rd);
        exp_rx0 = 8'hFF;
        chk("ovr_rx_data", rx_data0, exp_rx0);
        chk("ovr_rx_valid", rx_valid0, 1'b1);
        chk("ovr_pulses", ovr0 - o0, 1);
        ack0();

        // Transmit 0x5A; a second load while full must be ignored.
        load0(8'h5A);
        chk("tx_ready_full", tx_ready0, 1'b0);
        load0(8'hC3);
        spi0_frame(8'h00, rd);
        exp_rx0 = 8'h00;
        chk("tx_miso_5a", rd, 8'h5A);
        chk("tx_ready_back", tx_ready0, 1'b1);
        chk("tx_rx_zero", rx_data0, exp_rx0);
        ack0();

        // sclk activity while deselected.
        spi0_bits(8'hAA, 8, rd);
        wait_cycles(8);
        chk("idle_miso", rd, 8'h00);
        chk("idle_rx_valid", rx_valid0, 1'b0);
        chk("idle_rx_data", rx_data0, exp_rx0);
        chk("idle_busy", busy0, 1'b0);

        // cs rises after 5 bits.
        f0 = ferr0;
        cs0 = 1'b0;
        #(2*H0);
        spi0_bits(8'hE7, 5, rd);
        #H0;
        cs0 = 1'b1;
        wait_cycles(8);
        chk("abort_frame_err", ferr0 - f0, 1);
        chk("abort_rx_valid", rx_valid0, 1'b0);
        chk("abort_rx_data", rx_data0, exp_rx0);

        // Two back-to-back words in one frame, first word transmits a loaded value.
        wa = 8'($urandom_range(0, 255));
        wb = 8'($urandom_range(0, 255));
        t  = 8'($urandom_range(0, 255));
        load0(t);
        o0 = ovr0;
        f0 = ferr0;
        cs0 = 1'b0;
        #(2*H0);
        chk("b2b_busy", busy0, 1'b1);
        spi0_bits(wa, 8, ra);
        spi0_bits(wb, 8, rb);
        #H0;
        cs0 = 1'b1;
        wait_cycles(8);
        exp_rx0 = wb;
        chk("b2b_rx_data", rx_data0, exp_rx0);
        chk("b2b_overrun", ovr0 - o0, 1);
        chk("b2b_frame_err", ferr0 - f0, 0);
        chk("b2b_miso_a", ra, t);
        chk("b2b_miso_b", rb, 8'h00);
        chk("b2b_tx_ready", tx_ready0, 1'b1);
        ack0();

        // Random single-word frames, transmit word loaded at random.
        for (int k = 0; k < 5; k++) begin
            w = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            do_load = 1'($urandom_range(0, 1));
            if (do_load) load0(t);
            spi0_frame(w, rd);
            exp_rx0 = w;
            chk("rnd_rx_data", rx_data0, exp_rx0);
            chk("rnd_rx_valid", rx_valid0, 1'b1);
            chk("rnd_miso", rd, do_load ? t : 8'h00);
            ack0();
        end

        // Mode 3, 16-bit LSB first: 0x1234 then 0xBEEF in one frame, then reset mid third word.
        t1 = 16'($urandom_range(0, 65535));
        @(negedge clk);
        tx_data1 = t1;
        tx_load1 = 1'b1;
        @(negedge clk) tx_load1 = 1'b0;
        o1 = ovr1;
        f1 = ferr1;
        cs1 = 1'b0;
        #(2*H1);
        spi1_bits(16'h1234, 16, rd1a);
        spi1_bits(16'hBEEF, 16, rd1b);
        spi1_bits(16'($urandom_range(0, 65535)), 7, rd1c);
        nq = got1.size();
        chk("m3_words", nq, 2);
        if (nq >= 2) begin
            chk("m3_word0", got1[0], 16'h1234);
            chk("m3_word1", got1[1], 16'hBEEF);
        end
        chk("m3_miso0", rd1a, t1);
        chk("m3_miso1", rd1b, 16'h0000);
        chk("m3_overrun", ovr1 - o1, 0);

        rst_n = 1'b0;
        cs1 = 1'b1;
        sclk1 = 1'b1;
        mosi1 = 1'b0;
        #1;
        chk("m3rst_miso", miso1, 1'b0);
        chk("m3rst_rx_data", rx_data1, 16'h0000);
        chk("m3rst_rx_valid", rx_valid1, 1'b0);
        chk("m3rst_overrun", rx_overrun1, 1'b0);
        chk("m3rst_tx_ready", tx_ready1, 1'b1);
        chk("m3rst_frame_err", frame_err1, 1'b0);
        chk("m3rst_busy", busy1, 1'b0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(6);
        chk("m3rst_no_ferr", ferr1 - f1, 0);
        chk("m3rst_no_word", got1.size(), 2);

        // Operation resumes on the next cs fall.
        w1 = 16'($urandom_range(0, 65535));
        cs1 = 1'b0;
        #(2*H1);
        spi1_bits(w1, 16, rd1a);
        #H1;
        cs1 = 1'b1;
        wait_cycles(8);
        nq = got1.size();
        chk("m3res_words", nq, 3);
        if (nq >= 1) chk("m3res_word", got1[nq-1], w1);
        chk("m3res_miso", rd1a, 16'h0000);
        chk("m3res_ferr", ferr1 - f1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
